// File: rtl/intpol2_pkg.sv
// Shared types and helpers for the quadratic interpolator output path.
package intpol2_pkg;

    localparam int unsigned DefDatapathWidth = 12;

    typedef struct packed {
        logic signed [DefDatapathWidth-1:0] i;
        logic signed [DefDatapathWidth-1:0] q;
    } iq_sample_t;

    localparam iq_sample_t IqSampleRst = '{i: '0, q: '0};

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                result++;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/intpol2_iq_ram.sv
// Simple dual-port {I,Q} sample array; combinational read port when INTPOL2_FIFO_FWFT_EN is
// defined, registered (read-enable gated, clearable) read port otherwise.
module intpol2_iq_ram
    import intpol2_pkg::*;
#(
    parameter int unsigned       Width  = 2 * DefDatapathWidth,
    parameter int unsigned       Depth  = 16,
    parameter int unsigned       AddrW  = clog2(Depth),
    parameter logic [Width-1:0]  RstVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef INTPOL2_FIFO_FWFT_EN
    assign rdata_o = mem_q[raddr_i];

    logic unused_ctrl;
    assign unused_ctrl = ^{rst_ni, clear_i, re_i};
`else
    logic [Width-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (clear_i) begin
            rdata_d = RstVal;
        end else if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= RstVal;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/intpol2_iq_out_fifo.sv
// I/Q output FIFO behind the interpolator core; afull feeds the core stall input.
// Define INTPOL2_FIFO_FWFT_EN for first-word fall-through reads, otherwise dout is registered.
module intpol2_iq_out_fifo
    import intpol2_pkg::*;
#(
    parameter int unsigned DATAPATH_WIDTH = DefDatapathWidth,
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter int unsigned AFULL_MARGIN   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [DATAPATH_WIDTH-1:0] din_i,
    input  logic [DATAPATH_WIDTH-1:0] din_q,
    input  logic                      rd_en,
    output logic [DATAPATH_WIDTH-1:0] dout_i,
    output logic [DATAPATH_WIDTH-1:0] dout_q,
    output logic                      empty,
    output logic                      full,
    output logic                      afull,
    output logic [DEPTH_LOG2:0]       level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned Width = 2 * DATAPATH_WIDTH;
    localparam logic [DEPTH_LOG2:0] LevelFull  = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0] LevelAfull = (DEPTH_LOG2 + 1)'(Depth - AFULL_MARGIN);
    localparam logic [Width-1:0]    SampleRst  = Width'(IqSampleRst);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  empty_q, empty_d, full_q, full_d, afull_q, afull_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  push, pop;
    logic [Width-1:0]      rdata, dout_word;

    always_comb begin
        push     = wr_en && !full_q;
        pop      = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
                default: level_d = level_q;
            endcase
            if (wr_en && full_q)  ovf_d = 1'b1;
            if (rd_en && empty_q) udf_d = 1'b1;
        end
        // Status flags come from the next-state level so they are registered, not decoded.
        empty_d = (level_d == '0);
        full_d  = (level_d == LevelFull);
        afull_d = (level_d >= LevelAfull);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    intpol2_iq_ram #(
        .Width  (Width),
        .Depth  (Depth),
        .AddrW  (DEPTH_LOG2),
        .RstVal (SampleRst)
    ) u_ram (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .clear_i (clear),
        .we_i    (push && !clear),
        .waddr_i (wr_ptr_q),
        .wdata_i ({din_i, din_q}),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

`ifdef INTPOL2_FIFO_FWFT_EN
    // Array is not reset, so mask the head while empty to keep the reset value visible.
    assign dout_word = empty_q ? SampleRst : rdata;
`else
    assign dout_word = rdata;
`endif

    assign dout_i    = dout_word[Width-1 -: DATAPATH_WIDTH];
    assign dout_q    = dout_word[DATAPATH_WIDTH-1:0];
    assign empty     = empty_q;
    assign full      = full_q;
    assign afull     = afull_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_intpol2_iq_out_fifo.sv
// Directed bench for intpol2_iq_out_fifo (DEPTH=16, AFULL_MARGIN=4), both read modes.
module tb_intpol2_iq_out_fifo;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         clear = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] din_i = '0;
    logic [W-1:0] din_q = '0;
    logic [W-1:0] dout_i, dout_q;
    logic         empty, full, afull, overflow, underflow;
    logic [4:0]   level;

    int tests = 0;
    int fails = 0;

    intpol2_iq_out_fifo #(
        .DATAPATH_WIDTH (W),
        .DEPTH_LOG2     (4),
        .AFULL_MARGIN   (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .wr_en     (wr_en),
        .din_i     (din_i),
        .din_q     (din_q),
        .rd_en     (rd_en),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
        rstn  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
    endtask

    task automatic push_n(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            wr_en = 1'b1;
            din_i = W'(base + k);
            din_q = W'(-(base + k));
            cycle();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", full); end
        tests++; if (afull !== 1'b0) begin fails++; $display("FAIL rst_afull got %b exp 0", afull); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL rst_level got %0d exp 0", level); end
        tests++;
        if (dout_i !== '0 || dout_q !== '0) begin
            fails++; $display("FAIL rst_dout got %h/%h exp 0/0", dout_i, dout_q);
        end
        tests++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL rst_sticky got %b%b exp 00", overflow, underflow);
        end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL idle_udf got %b exp 1", underflow); end
        tests++;
        if (dout_i !== '0 || dout_q !== '0) begin
            fails++; $display("FAIL idle_dout got %h/%h exp 0/0", dout_i, dout_q);
        end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL idle_level got %0d exp 0", level); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            wr_en = 1'b1;
            din_i = W'(k);
            din_q = W'(-k);
            cycle();
            tests++;
            if (level !== 5'(k)) begin fails++; $display("FAIL fill_level got %0d exp %0d", level, k); end
            tests++;
            if (afull !== (k >= 12)) begin
                fails++; $display("FAIL fill_afull k=%0d got %b exp %b", k, afull, k >= 12);
            end
            tests++;
            if (full !== (k == 16)) begin
                fails++; $display("FAIL fill_full k=%0d got %b exp %b", k, full, k == 16);
            end
        end
        din_i = W'(17);
        din_q = W'(-17);
        cycle();
        wr_en = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b exp 1", overflow); end
        tests++; if (level !== 5'd16) begin fails++; $display("FAIL ovf_level got %0d exp 16", level); end
        for (int k = 1; k <= 16; k++) begin
            rd_en = 1'b1;
`ifndef INTPOL2_FIFO_FWFT_EN
            cycle();
`endif
            tests++;
            if (dout_i !== W'(k) || dout_q !== W'(-k)) begin
                fails++;
                $display("FAIL drain_data k=%0d got %0d/%0d exp %0d/%0d", k,
                         $signed(dout_i), $signed(dout_q), k, -k);
            end
`ifdef INTPOL2_FIFO_FWFT_EN
            cycle();
`endif
        end
        rd_en = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", empty); end
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL drain_udf got %b exp 0", underflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_n(5, 100);
        for (int n = 0; n < 40; n++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            din_i = W'(105 + n);
            din_q = W'(-(105 + n));
`ifdef INTPOL2_FIFO_FWFT_EN
            tests++;
            if (dout_i !== W'(100 + n) || dout_q !== W'(-(100 + n))) begin
                fails++; $display("FAIL b2b_data n=%0d got %0d exp %0d", n, dout_i, 100 + n);
            end
            cycle();
`else
            cycle();
            tests++;
            if (dout_i !== W'(100 + n) || dout_q !== W'(-(100 + n))) begin
                fails++; $display("FAIL b2b_data n=%0d got %0d exp %0d", n, dout_i, 100 + n);
            end
`endif
            tests++;
            if (level !== 5'd5) begin fails++; $display("FAIL b2b_level n=%0d got %0d exp 5", n, level); end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_full_rw();
        do_reset();
        push_n(16, 1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        din_i = W'(99);
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tests++; if (level !== 5'd15) begin fails++; $display("FAIL fullrw_level got %0d exp 15", level); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fullrw_ovf got %b exp 1", overflow); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL fullrw_full got %b exp 0", full); end
        tests++; if (afull !== 1'b1) begin fails++; $display("FAIL fullrw_afull got %b exp 1", afull); end
    endtask

    task automatic test_empty_rw();
        do_reset();
        wr_en = 1'b1;
        rd_en = 1'b1;
        din_i = W'(7);
        din_q = W'(-7);
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL emptyrw_level got %0d exp 1", level); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL emptyrw_udf got %b exp 1", underflow); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL emptyrw_empty got %b exp 0", empty); end
`ifdef INTPOL2_FIFO_FWFT_EN
        tests++;
        if (dout_i !== W'(7) || dout_q !== W'(-7)) begin
            fails++; $display("FAIL emptyrw_dout got %0d exp 7", dout_i);
        end
`else
        tests++;
        if (dout_i !== '0 || dout_q !== '0) begin
            fails++; $display("FAIL emptyrw_dout got %0d exp 0", dout_i);
        end
`endif
    endtask

    task automatic test_clear();
        do_reset();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        push_n(10, 20);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        tests++; if (level !== 5'd9) begin fails++; $display("FAIL clr_pre_level got %0d exp 9", level); end
        clear = 1'b1;
        wr_en = 1'b1;
        din_i = W'(77);
        cycle();
        clear = 1'b0;
        wr_en = 1'b0;
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL clr_level got %0d exp 0", level); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL clr_empty got %b exp 1", empty); end
        tests++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            fails++; $display("FAIL clr_sticky got %b%b exp 00", overflow, underflow);
        end
        tests++; if (dout_i !== '0) begin fails++; $display("FAIL clr_dout got %0d exp 0", dout_i); end
        push_n(1, 55);
`ifdef INTPOL2_FIFO_FWFT_EN
        tests++; if (dout_i !== W'(55)) begin fails++; $display("FAIL clr_fwft_lat got %0d exp 55", dout_i); end
`else
        tests++; if (dout_i !== '0) begin fails++; $display("FAIL clr_std_hold got %0d exp 0", dout_i); end
`endif
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
`ifndef INTPOL2_FIFO_FWFT_EN
        tests++; if (dout_i !== W'(55)) begin fails++; $display("FAIL clr_std_lat got %0d exp 55", dout_i); end
`endif
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL clr_pop_empty got %b exp 1", empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_n(3, 1);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL arst_level got %0d exp 0", level); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL arst_empty got %b exp 1", empty); end
        tests++; if (dout_i !== '0) begin fails++; $display("FAIL arst_dout got %0d exp 0", dout_i); end
        @(negedge clk);
        rstn = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_empty_rw();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
